// File: rtl/cud_wrap_monitor.sv
// cud_wrap_monitor
//   Watches the 2-bit up/down counter (q, l) and classifies every sampled
//   step as hold / up / down / illegal. Produces one-cycle wrap pulses,
//   saturating wrap counters, a saturating count of cycles with l=1 and a
//   sticky fault flag that only reset clears.
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   q         in   [1:0] upstream counter value
//   l         in   upstream G-block output L
//   dir       out  [1:0] last step: 00 hold, 01 up, 10 down, 11 fault
//   wrap_up   out  one-cycle pulse after a 3->0 step
//   wrap_dn   out  one-cycle pulse after a 0->3 step
//   up_wraps  out  [WCNT_W-1:0] saturating count of wrap_up events
//   dn_wraps  out  [WCNT_W-1:0] saturating count of wrap_dn events
//   l_cycles  out  [LCNT_W-1:0] saturating count of cycles with l=1
//   err       out  sticky illegal-transition flag
module cud_wrap_monitor #(
  parameter int unsigned WCNT_W = 4,
  parameter int unsigned LCNT_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        q,
  input  logic              l,
  output logic [1:0]        dir,
  output logic              wrap_up,
  output logic              wrap_dn,
  output logic [WCNT_W-1:0] up_wraps,
  output logic [WCNT_W-1:0] dn_wraps,
  output logic [LCNT_W-1:0] l_cycles,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam logic [WCNT_W-1:0] WONE = WCNT_W'(1);
  localparam logic [LCNT_W-1:0] LONE = LCNT_W'(1);

  state_e              state_q;
  logic [1:0]          q_prev_q;
  logic [1:0]          dir_q;
  logic                wrap_up_q;
  logic                wrap_dn_q;
  logic [WCNT_W-1:0]   up_wraps_q;
  logic [WCNT_W-1:0]   dn_wraps_q;
  logic [LCNT_W-1:0]   l_cycles_q;
  logic                err_q;

  logic [1:0]          step_d;
  logic                up_wrap_d;
  logic                dn_wrap_d;

  // 2-bit subtraction gives (q - q_prev) mod 4 directly. A +1 step landing
  // on 0 can only come from 3, a -1 step landing on 3 only from 0.
  always_comb begin
    step_d    = q - q_prev_q;
    up_wrap_d = (step_d == 2'd1) && (q == 2'd0);
    dn_wrap_d = (step_d == 2'd3) && (q == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      q_prev_q   <= '0;
      dir_q      <= '0;
      wrap_up_q  <= 1'b0;
      wrap_dn_q  <= 1'b0;
      up_wraps_q <= '0;
      dn_wraps_q <= '0;
      l_cycles_q <= '0;
      err_q      <= 1'b0;
    end else begin
      q_prev_q  <= q;
      wrap_up_q <= 1'b0;
      wrap_dn_q <= 1'b0;

      if (l && (l_cycles_q != '1)) begin
        l_cycles_q <= l_cycles_q + LONE;
      end

      unique case (state_q)
        ST_INIT: begin
          dir_q   <= 2'b00;
          state_q <= ST_TRACK;
        end
        ST_TRACK: begin
          unique case (step_d)
            2'd0: dir_q <= 2'b00;
            2'd1: begin
              dir_q <= 2'b01;
              if (up_wrap_d) begin
                wrap_up_q <= 1'b1;
                if (up_wraps_q != '1) up_wraps_q <= up_wraps_q + WONE;
              end
            end
            2'd3: begin
              dir_q <= 2'b10;
              if (dn_wrap_d) begin
                wrap_dn_q <= 1'b1;
                if (dn_wraps_q != '1) dn_wraps_q <= dn_wraps_q + WONE;
              end
            end
            default: begin
              dir_q   <= 2'b11;
              err_q   <= 1'b1;
              state_q <= ST_FAULT;
            end
          endcase
        end
        ST_FAULT: begin
          dir_q <= 2'b11;
          err_q <= 1'b1;
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign dir      = dir_q;
  assign wrap_up  = wrap_up_q;
  assign wrap_dn  = wrap_dn_q;
  assign up_wraps = up_wraps_q;
  assign dn_wraps = dn_wraps_q;
  assign l_cycles = l_cycles_q;
  assign err      = err_q;

endmodule

// File: tb/tb_cud_wrap_monitor.sv
// tb_cud_wrap_monitor
//   Self-checking bench for cud_wrap_monitor. Directed sequences from the
//   test plan plus a randomized phase, all checked every cycle against a
//   behavioural model built from the step-classification rules.
module tb_cud_wrap_monitor;

  localparam int WW = 4;
  localparam int LW = 6;
  localparam int WMAX = (1 << WW) - 1;
  localparam int LMAX = (1 << LW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    q;
  logic          l;
  logic [1:0]    dir;
  logic          wrap_up;
  logic          wrap_dn;
  logic [WW-1:0] up_wraps;
  logic [WW-1:0] dn_wraps;
  logic [LW-1:0] l_cycles;
  logic          err;

  cud_wrap_monitor #(.WCNT_W(WW), .LCNT_W(LW)) dut (
    .clk      (clk),
    .reset    (reset),
    .q        (q),
    .l        (l),
    .dir      (dir),
    .wrap_up  (wrap_up),
    .wrap_dn  (wrap_dn),
    .up_wraps (up_wraps),
    .dn_wraps (dn_wraps),
    .l_cycles (l_cycles),
    .err      (err)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: "seen a sample since reset", "illegal step seen",
  // previous sample and the expected output values.
  bit m_started, m_faulted;
  int m_prev, m_dir, m_wu, m_wd, m_uw, m_dw, m_lc, m_err;
  int cur_q;
  int wu_seen;

  task automatic model_edge(input bit r, input int qv, input bit lv);
    int d;
    if (r) begin
      m_started = 0; m_faulted = 0; m_prev = 0;
      m_dir = 0; m_wu = 0; m_wd = 0; m_uw = 0; m_dw = 0; m_lc = 0; m_err = 0;
      return;
    end
    m_wu = 0;
    m_wd = 0;
    if (lv && m_lc < LMAX) m_lc = m_lc + 1;
    if (!m_started) begin
      m_started = 1;
      m_dir = 0;
    end else if (m_faulted) begin
      m_dir = 3;
      m_err = 1;
    end else begin
      d = (qv - m_prev + 4) % 4;
      if (d == 0) m_dir = 0;
      else if (d == 1) begin
        m_dir = 1;
        if (m_prev == 3 && qv == 0) begin
          m_wu = 1;
          if (m_uw < WMAX) m_uw = m_uw + 1;
        end
      end else if (d == 3) begin
        m_dir = 2;
        if (m_prev == 0 && qv == 3) begin
          m_wd = 1;
          if (m_dw < WMAX) m_dw = m_dw + 1;
        end
      end else begin
        m_dir = 3;
        m_err = 1;
        m_faulted = 1;
      end
    end
    m_prev = qv;
  endtask

  task automatic step(input bit r, input int qv, input bit lv, input string tag);
    reset = r;
    q     = 2'(qv);
    l     = lv;
    cur_q = qv;
    @(posedge clk);
    model_edge(r, qv, lv);
    #1;
    check_eq({tag, ".dir"},      dir,      m_dir);
    check_eq({tag, ".wrap_up"},  wrap_up,  m_wu);
    check_eq({tag, ".wrap_dn"},  wrap_dn,  m_wd);
    check_eq({tag, ".up_wraps"}, up_wraps, m_uw);
    check_eq({tag, ".dn_wraps"}, dn_wraps, m_dw);
    check_eq({tag, ".l_cycles"}, l_cycles, m_lc);
    check_eq({tag, ".err"},      err,      m_err);
    if (wrap_up) wu_seen++;
  endtask

  initial begin
    int up_seq[6]  = '{0, 1, 2, 3, 0, 1};
    int dn_seq[5]  = '{2, 1, 0, 3, 2};
    int flt_seq[5] = '{1, 3, 3, 0, 1};
    int uw_before;
    int roll;
    int qn;
    bit rr;

    reset = 1'b1; q = 2'd0; l = 1'b0; cur_q = 0; wu_seen = 0;

    // Reset, then idle at 0.
    for (int i = 0; i < 3; i++) step(1, 0, 0, "rst");
    for (int i = 0; i < 4; i++) step(0, 0, 0, "idle");
    check_eq("idle_err", err, 0);

    // Up counting through a wrap.
    wu_seen = 0;
    foreach (up_seq[i]) step(0, up_seq[i], 0, "up");
    check_eq("up_pulses", wu_seen, 1);
    check_eq("up_wraps_1", up_wraps, 1);
    check_eq("dn_wraps_0", dn_wraps, 0);

    // Down counting through a wrap.
    foreach (dn_seq[i]) step(0, dn_seq[i], 0, "dn");
    check_eq("dn_wraps_1", dn_wraps, 1);

    // Illegal jump 1->3, then frozen wraps while in fault.
    uw_before = 1;
    foreach (flt_seq[i]) step(0, flt_seq[i], 0, "flt");
    check_eq("flt_err", err, 1);
    check_eq("flt_dir", dir, 3);
    check_eq("flt_upw", up_wraps, uw_before);
    step(1, 1, 0, "flt_rst");
    check_eq("flt_rst_err", err, 0);
    // First edge after reset is INIT: a jump here is never classified.
    step(0, 3, 0, "init_jump");
    check_eq("init_jump_err", err, 0);

    // l_cycles saturation.
    step(1, 0, 1, "lsat_rst");
    for (int i = 0; i < 70; i++) step(0, 0, 1, "lsat");
    check_eq("lsat_final", l_cycles, 63);

    // 20 up-wraps: counter saturates, pulses continue.
    step(1, 0, 0, "wsat_rst");
    step(0, 0, 0, "wsat_init");
    wu_seen = 0;
    for (int w = 0; w < 20; w++) begin
      step(0, 1, 0, "wsat");
      step(0, 2, 0, "wsat");
      step(0, 3, 0, "wsat");
      step(0, 0, 0, "wsat");
    end
    check_eq("wsat_cnt", up_wraps, 15);
    check_eq("wsat_pulses", wu_seen, 20);

    // Randomized walk: mostly legal steps, occasional jumps and resets.
    for (int i = 0; i < 600; i++) begin
      rr   = ($urandom_range(0, 39) == 0);
      roll = $urandom_range(0, 19);
      if (roll == 0)       qn = $urandom_range(0, 3);
      else if (roll < 6)   qn = cur_q;
      else if (roll < 13)  qn = (cur_q + 1) % 4;
      else                 qn = (cur_q + 3) % 4;
      step(rr, qn, 1'($urandom_range(0, 1)), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
